// File: rtl/seq_arith_pkg.sv
// rtl/seq_arith_pkg.sv - shared op encoding and FSM state types for seq_arith_unit
package seq_arith_pkg;

  typedef enum logic [1:0] {
    ADD = 2'b00,
    SUB = 2'b01,
    MUL = 2'b10,
    DIV = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/addsub_w.sv
// rtl/addsub_w.sv - combinational N-bit adder/subtractor shared by every operation
module addsub_w #(
  parameter int N = 9
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         sub,
  output logic [N-1:0] sum
);

  assign sum = sub ? (x - y) : (x + y);

endmodule

// File: rtl/seq_arith_unit.sv
// rtl/seq_arith_unit.sv - sequential add/sub, Booth multiply and restoring divide
module seq_arith_unit
  import seq_arith_pkg::*;
#(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [1:0]     op,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] result,
  output logic           div_by_zero
);

  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  state_e        state, state_n;
  op_e           op_r;
  op_e           op_in;
  logic [W:0]    hi;
  logic [W-1:0]  lo;
  logic [W-1:0]  m;
  logic          qm1;
  logic [CW-1:0] cnt;

  logic [W:0]    add_x, add_y, add_sum;
  logic          add_sub;
  logic [W:0]    next_hi;
  logic [W-1:0]  next_lo;
  logic          next_qm1;
  logic          fast_path;

  assign op_in     = op_e'(op);
  assign fast_path = (op_in == ADD) || (op_in == SUB) || ((op_in == DIV) && (b == '0));
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

  addsub_w #(.N(W + 1)) u_addsub (
    .x   (add_x),
    .y   (add_y),
    .sub (add_sub),
    .sum (add_sum)
  );

  // In IDLE the adder serves add/sub on the live operands; in CALC it is the Booth or trial-subtract step.
  always_comb begin
    add_x   = {a[W-1], a};
    add_y   = {b[W-1], b};
    add_sub = (op_in == SUB);
    if (state == CALC) begin
      if (op_r == MUL) begin
        add_x   = hi;
        add_y   = {m[W-1], m};
        add_sub = lo[0] & ~qm1;
      end else begin
        add_x   = {hi[W-1:0], lo[W-1]};
        add_y   = {1'b0, m};
        add_sub = 1'b1;
      end
    end
  end

  // Booth: add/sub/skip then arithmetic shift of {hi,lo,qm1}; divide: keep the trial remainder unless it borrowed.
  always_comb begin
    next_hi  = hi;
    next_lo  = lo;
    next_qm1 = 1'b0;
    if (op_r == MUL) begin
      if (lo[0] == qm1) begin
        next_hi = {hi[W], hi[W:1]};
        next_lo = {hi[0], lo[W-1:1]};
      end else begin
        next_hi = {add_sum[W], add_sum[W:1]};
        next_lo = {add_sum[0], lo[W-1:1]};
      end
      next_qm1 = lo[0];
    end else begin
      next_hi = add_sum[W] ? {hi[W-1:0], lo[W-1]} : add_sum;
      next_lo = {lo[W-2:0], ~add_sum[W]};
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = fast_path ? DONE : CALC;
      CALC:    if (cnt == CNT_LAST) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      op_r        <= ADD;
      hi          <= '0;
      lo          <= '0;
      m           <= '0;
      qm1         <= 1'b0;
      cnt         <= '0;
      result      <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: begin
          if (start) begin
            op_r        <= op_in;
            m           <= b;
            hi          <= '0;
            lo          <= a;
            qm1         <= 1'b0;
            cnt         <= '0;
            div_by_zero <= 1'b0;
            if ((op_in == ADD) || (op_in == SUB)) begin
              result <= {{(W-1){add_sum[W]}}, add_sum};
            end else if ((op_in == DIV) && (b == '0)) begin
              result      <= {a, {W{1'b1}}};
              div_by_zero <= 1'b1;
            end
          end
        end
        CALC: begin
          hi  <= next_hi;
          lo  <= next_lo;
          qm1 <= next_qm1;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) result <= {next_hi[W-1:0], next_lo};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/seq_arith_unit.md
SEQ_ARITH_UNIT -- requirements
Module: seq_arith_unit

Interface
REQ-001 SHALL have parameter: W, 8, operand width in bits (even, 4..32).
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port: start  input  1  request; sampled only while idle.
REQ-005 SHALL have port: op  input  2  operation: 00 add, 01 sub, 10 mul, 11 div.
REQ-006 SHALL have port: a  input  W  first operand / dividend.
REQ-007 SHALL have port: b  input  W  second operand / divisor.
REQ-008 SHALL have port: busy  output  1  high whenever state is not IDLE.
REQ-009 SHALL have port: done  output  1  one-cycle pulse; result valid.
REQ-010 SHALL have port: result  output  2W  registered result.
REQ-011 SHALL have port: div_by_zero  output  1  set with done when op=div and b=0.

Function
REQ-012 SHALL implement FSM states IDLE, CALC, DONE.
REQ-013 SHALL accept start in IDLE only: capture op, a, b in that cycle (edge N); start while busy is ignored, with no queueing.
REQ-014 SHALL transition from IDLE to DONE for add, sub and div with b=0, and from IDLE to CALC for mul and for div with b!=0.
REQ-015 SHALL stay in CALC for exactly W cycles, using an iteration counter of clog2(W) bits cleared on accept; CALC goes to DONE when the counter reaches W-1.
REQ-016 SHALL spend exactly one cycle in DONE with done=1, then return to IDLE; start is ignored in DONE.
REQ-017 SHALL therefore have latency, counted from accept edge N: add/sub/div-by-zero done in cycle N+1; mul/div done in cycle N+W+1.
REQ-018 SHALL compute add/sub as signed two's complement: the W+1-bit exact a+b or a-b, sign-extended to 2W bits.
REQ-019 SHALL compute mul as signed radix-2 Booth: a two's-complement product of exactly 2W bits, one add/sub/skip plus arithmetic right shift per CALC cycle.
REQ-020 SHALL compute div as unsigned restoring division, one quotient bit per CALC cycle: result[W-1:0]=quotient, result[2W-1:W]=remainder.
REQ-021 SHALL, for div with b=0, skip CALC and return quotient all ones and remainder=a, with div_by_zero=1.
REQ-022 SHALL clear div_by_zero on the next accepted start.
REQ-023 SHALL update result only on entry to DONE, and hold it stable until the DONE entry of the next operation.
REQ-024 SHALL NOT let operand input changes after accept affect the operation in flight.
REQ-025 SHALL reuse one W+1-bit add/sub datapath for every op.

Reset
REQ-026 SHALL, with rst=1 at an edge, enter IDLE with busy=0, done=0, result=0, div_by_zero=0, counter=0 and internal working registers 0.
REQ-027 SHALL abort an operation in flight when rst is asserted mid-operation, producing no done pulse.
REQ-028 SHALL ignore start in any cycle in which rst=1.

Structure
REQ-029 SHALL take the op encoding typedef (ADD/SUB/MUL/DIV) and the FSM state typedef from shared package seq_arith_pkg.
REQ-030 SHALL instantiate one sub-module, addsub_w (parametrised by width, combinational add/sub with op select), as the shared datapath adder.

Verification
REQ-031 SHALL cover, at W=8: add a=0x7F, b=0x01 -> done in cycle N+1, result=0x0080; and sub a=0x00, b=0x01 -> result=0xFFFF.
REQ-032 SHALL cover, at W=8: mul a=0xFD (-3), b=0x07 -> done in cycle N+9, result=0xFFEB; and a=0x80, b=0x80 -> result=0x4000.
REQ-033 SHALL cover, at W=8: div a=0xC8 (200), b=0x07 -> done in cycle N+9, result=0x041C, div_by_zero=0.
REQ-034 SHALL cover, at W=8: div a=0xC8, b=0x00 -> done in cycle N+1, result=0xC8FF, div_by_zero=1; the next accepted add clears div_by_zero.
REQ-035 SHALL cover: rst at cycle N+4 of a mul -> next cycle busy=0, done=0, result=0, and no later done pulse; start held high throughout a mul -> exactly one accept, and a new accept only in the IDLE cycle after DONE.
REQ-036 SHALL cover, at W=16: 200 random mul/div operations against a reference model, with latency always 17 cycles.
